piso_tx: RTL

- Parallel-in, serial-out frame transmitter.
- Sits on the driving end of the single-wire serial links our shift-register chains consume (e.g. the `in` pin of a SISO/SIPO stage).
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on one line as a frame: start bit (0), data bits, optional even-parity bit, stop bit (1).
- Holds the line high when idle.

---
 rtl/piso_tx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx: parallel-in, serial-out frame transmitter.
//
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out on a
// single line as: start bit (0), data bits, optional even-parity bit, stop
// bit (1). Every bit is held for CLKS_PER_BIT clocks. The line idles high.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous reset, active low
//   in_data   in   word to transmit, sampled only on handshake
//   in_valid  in   producer has a word on in_data
//   in_ready  out  transmitter can accept a word this cycle (registered)
//   out       out  serial line (registered)
//   busy      out  frame in progress (registered)
//   done      out  one-cycle pulse when a frame's stop bit completes
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Even parity: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    baud_cnt_q, baud_cnt_d;
    logic             parity_q, parity_d;
    logic             out_q, out_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_end_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] shifted_s;

    // Bit-order helpers: the bit to drive next is always at the shift-out end,
    // and shifting discards it so the following bit moves into place.
    always_comb begin
        bit_end_s = (baud_cnt_q == BAUD_LAST);
        if (LSB_FIRST != 0) begin
            next_bit_s = shreg_q[0];
            shifted_s  = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
            next_bit_s = shreg_q[WIDTH-1];
            shifted_s  = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        parity_d   = parity_q;
        out_d      = out_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // Baud counter runs 0..CLKS_PER_BIT-1 and reloads on each bit boundary.
        if (bit_end_s) begin
            baud_cnt_d = '0;
        end else begin
            baud_cnt_d = baud_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (in_valid && in_ready_q) begin
                    shreg_d    = in_data;
                    parity_d   = even_parity(in_data);
                    out_d      = 1'b0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end else begin
                    out_d      = 1'b1;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    out_d     = next_bit_s;
                    shreg_d   = shifted_s;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            out_d   = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            out_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        out_d     = next_bit_s;
                        shreg_d   = shifted_s;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    out_d   = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    out_d      = 1'b1;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                out_d      = 1'b1;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            parity_q   <= 1'b0;
            out_q      <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            parity_q   <= parity_d;
            out_q      <= out_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign out      = out_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
